addsub_share_arbiter: RTL

Shares one WIDTH-bit ripple adder/subtractor datapath between two requesters. Each requester uses a valid/ready request channel and a valid/ready response channel. A round-robin arbiter grants the datapath to one requester at a time. The block registers the operands, computes sum, carry-out and signed overflow, and holds the result until the owning requester accepts it. It sits between the operand sources and the shared add/sub datapath.

---
 rtl/addsub_share_arbiter.sv | 85 ++++++++
 1 files changed

// File: rtl/addsub_share_arbiter.sv
// addsub_share_arbiter: round-robin two-port front end sharing one registered ripple add/sub datapath
module addsub_share_arbiter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_m,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_m,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_s,
   output logic             rsp_cout,
   output logic             rsp_ovf,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t state, state_nx;
   logic last_grant, owner, grant, take, done, m_r, cy, c_msb;
   logic [WIDTH-1:0] a_r, b_r, bx, s_nx;
   // grant selects port 1 when it alone is valid, or on a tie when port 0 won last
   assign grant = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
   assign req0_ready = state == IDLE & req0_valid & ~grant;
   assign req1_ready = state == IDLE & req1_valid & grant;
   assign take = req0_ready | req1_ready;
   assign rsp0_valid = state == RESP & ~owner;
   assign rsp1_valid = state == RESP & owner;
   assign done = owner ? rsp1_valid & rsp1_ready : rsp0_valid & rsp0_ready;
   assign busy = state != IDLE;
   assign bx = b_r ^ {WIDTH{m_r}};
   always_comb begin
      state_nx = (state == IDLE & take) ? EXEC :
                 (state == EXEC)        ? RESP :
                 (state == RESP & done) ? IDLE : state;
   end
   // carry kept in a scalar so the ripple chain stays a simple unrolled loop
   always_comb begin
      cy = m_r;
      c_msb = 1'b0;
      s_nx = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (i == WIDTH - 1) c_msb = cy;
         s_nx[i] = a_r[i] ^ bx[i] ^ cy;
         cy = (a_r[i] & bx[i]) | (cy & (a_r[i] ^ bx[i]));
      end
   end
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_nx;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         owner <= 1'b0;
         a_r <= '0;
         b_r <= '0;
         m_r <= 1'b0;
         rsp_s <= '0;
         rsp_cout <= 1'b0;
         rsp_ovf <= 1'b0;
      end else begin
         if (take) begin
            a_r <= grant ? req1_a : req0_a;
            b_r <= grant ? req1_b : req0_b;
            m_r <= grant ? req1_m : req0_m;
            owner <= grant;
            last_grant <= grant;
         end
         if (state == EXEC) begin
            rsp_s <= s_nx;
            rsp_cout <= cy;
            rsp_ovf <= c_msb ^ cy;
         end
      end
   end
endmodule
